// File: rtl/bananachine_pkg.sv
// Shared definitions for the fetch front end.
// - fetch_state_t : fetch FSM state encoding (IDLE, REQ, VALID, ERR)
// - PC_SRC_*      : next-PC select codes driven on pc_src
package bananachine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;  // pc + 1
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;  // pc + sext(imm)
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;  // jump_target
    localparam logic [1:0] PC_SRC_HOLD   = 2'd3;  // keep pc

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC adder and select.
// Ports:
//   pc          in  current program counter
//   imm         in  raw instruction immediate (always sign-extended here)
//   jump_target in  register-sourced absolute target
//   pc_src      in  select code (PC_SRC_*)
//   next_pc     out selected next program counter
//   link_pc     out pc + 1 (return address)
// All arithmetic wraps modulo 2^WIDTH.
module pc_next_sel
    import bananachine_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IMM_BITS = 8
) (
    input  logic [WIDTH-1:0]    pc,
    input  logic [IMM_BITS-1:0] imm,
    input  logic [WIDTH-1:0]    jump_target,
    input  logic [1:0]          pc_src,
    output logic [WIDTH-1:0]    next_pc,
    output logic [WIDTH-1:0]    link_pc
);

    logic signed [WIDTH-1:0] imm_sext;

    // Branch offsets are signed regardless of how the immediate is presented
    // to the datapath.
    assign imm_sext = {{(WIDTH-IMM_BITS){imm[IMM_BITS-1]}}, imm};
    assign link_pc  = pc + WIDTH'(1);

    always_comb begin
        next_pc = pc;
        case (pc_src)
            PC_SRC_INC:    next_pc = link_pc;
            PC_SRC_BRANCH: next_pc = pc + imm_sext;
            PC_SRC_JUMP:   next_pc = jump_target;
            default:       next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch unit.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   fetch_en            request the next instruction
//   pc_load, pc_src     commit next PC (VALID only) and its source select
//   jump_target         absolute jump address
//   imm_sign_ext        1: immediate output sign-extended, 0: zero-extended
//   mem_ready/mem_rdata memory handshake and returned instruction word
//   mem_req/mem_addr    fetch request and address (address = pc)
//   ins_valid + fields  decoded instruction fields (op_code, a_index,
//                       ext_op_code, b_index, immediate)
//   pc, link_pc         current pc and pc + 1
//   fetch_timeout       sticky flag: memory did not answer within MAX_WAIT
module pc_fetch_unit
    import bananachine_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter int          OP_BITS  = 4,
    parameter int          REG_BITS = 4,
    parameter int          IMM_BITS = 8,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_en,
    input  logic                pc_load,
    input  logic [1:0]          pc_src,
    input  logic [WIDTH-1:0]    jump_target,
    input  logic                imm_sign_ext,
    input  logic                mem_ready,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                mem_req,
    output logic [WIDTH-1:0]    mem_addr,
    output logic                ins_valid,
    output logic [OP_BITS-1:0]  op_code,
    output logic [REG_BITS-1:0] a_index,
    output logic [OP_BITS-1:0]  ext_op_code,
    output logic [REG_BITS-1:0] b_index,
    output logic [WIDTH-1:0]    immediate,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    link_pc,
    output logic                fetch_timeout
);

    localparam int               CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] ins_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] next_pc;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             mem_req_q, ins_valid_q, timeout_q;

    logic latch_ins, load_pc, cnt_clr, cnt_inc, timeout_set, timeout_clr;

    pc_next_sel #(
        .WIDTH    (WIDTH),
        .IMM_BITS (IMM_BITS)
    ) u_pc_next_sel (
        .pc          (pc_q),
        .imm         (ins_q[IMM_BITS-1:0]),
        .jump_target (jump_target),
        .pc_src      (pc_src),
        .next_pc     (next_pc),
        .link_pc     (link_pc)
    );

    always_comb begin
        state_d     = state_q;
        latch_ins   = 1'b0;
        load_pc     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        timeout_set = 1'b0;
        timeout_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_en) begin
                    state_d = ST_REQ;
                    cnt_clr = 1'b1;
                end
            end
            ST_REQ: begin
                // A response on the final wait cycle still wins over timeout.
                if (mem_ready) begin
                    state_d   = ST_VALID;
                    latch_ins = 1'b1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_ERR;
                    timeout_set = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_VALID: begin
                if (pc_load) begin
                    load_pc = 1'b1;
                    if (fetch_en) begin
                        state_d = ST_REQ;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                // Retry at the same pc; the flag clears as the retry starts.
                if (fetch_en) begin
                    state_d     = ST_REQ;
                    cnt_clr     = 1'b1;
                    timeout_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= WIDTH'(RESET_PC);
            ins_q       <= '0;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            ins_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= (state_d == ST_REQ);
            ins_valid_q <= (state_d == ST_VALID);
            if (latch_ins)   ins_q      <= mem_rdata;
            if (load_pc)     pc_q       <= next_pc;
            if (cnt_clr)     wait_cnt_q <= '0;
            else if (cnt_inc) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (timeout_set)      timeout_q <= 1'b1;
            else if (timeout_clr) timeout_q <= 1'b0;
        end
    end

    assign mem_req       = mem_req_q;
    assign ins_valid     = ins_valid_q;
    assign fetch_timeout = timeout_q;
    assign pc            = pc_q;
    assign mem_addr      = pc_q;

    assign b_index     = ins_q[REG_BITS-1:0];
    assign ext_op_code = ins_q[REG_BITS +: OP_BITS];
    assign a_index     = ins_q[REG_BITS+OP_BITS +: REG_BITS];
    assign op_code     = ins_q[2*REG_BITS+OP_BITS +: OP_BITS];
    assign immediate   = imm_sign_ext
                       ? {{(WIDTH-IMM_BITS){ins_q[IMM_BITS-1]}}, ins_q[IMM_BITS-1:0]}
                       : {{(WIDTH-IMM_BITS){1'b0}}, ins_q[IMM_BITS-1:0]};

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en, pc_load, imm_sign_ext, mem_ready;
    logic [1:0]  pc_src;
    logic [15:0] jump_target, mem_rdata;
    logic        mem_req, ins_valid, fetch_timeout;
    logic [15:0] mem_addr, immediate, pc, link_pc;
    logic [3:0]  op_code, a_index, ext_op_code, b_index;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .pc_load       (pc_load),
        .pc_src        (pc_src),
        .jump_target   (jump_target),
        .imm_sign_ext  (imm_sign_ext),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .ins_valid     (ins_valid),
        .op_code       (op_code),
        .a_index       (a_index),
        .ext_op_code   (ext_op_code),
        .b_index       (b_index),
        .immediate     (immediate),
        .pc            (pc),
        .link_pc       (link_pc),
        .fetch_timeout (fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; pc_load = 1'b0; pc_src = 2'd0;
        jump_target = 16'h0; imm_sign_ext = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0;
        repeat (2) step();

        // reset state
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_ins_valid", 32'(ins_valid), 32'h0);
        check("rst_timeout", 32'(fetch_timeout), 32'h0);
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_link_pc", 32'(link_pc), 32'h0001);
        check("rst_op_code", 32'(op_code), 32'h0);

        // first fetch, ready on the first REQ cycle
        reset = 1'b0; fetch_en = 1'b1;
        step();
        check("req_mem_req", 32'(mem_req), 32'h1);
        check("req_mem_addr", 32'(mem_addr), 32'h0000);
        fetch_en = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h3A5C;
        step();
        mem_ready = 1'b0; mem_rdata = 16'h0;
        check("dec_ins_valid", 32'(ins_valid), 32'h1);
        check("dec_op_code", 32'(op_code), 32'h3);
        check("dec_a_index", 32'(a_index), 32'hA);
        check("dec_ext_op", 32'(ext_op_code), 32'h5);
        check("dec_b_index", 32'(b_index), 32'hC);
        check("dec_mem_req", 32'(mem_req), 32'h0);
        check("dec_imm_zext", 32'(immediate), 32'h005C);
        step();
        check("hold_ins_valid", 32'(ins_valid), 32'h1);
        check("hold_op_code", 32'(op_code), 32'h3);

        // jump to 0x0010 and fetch a word with imm = 0xFE
        pc_load = 1'b1; pc_src = 2'd2; jump_target = 16'h0010; fetch_en = 1'b1;
        step();
        pc_load = 1'b0; fetch_en = 1'b0;
        check("jmp_pc", 32'(pc), 32'h0010);
        check("jmp_mem_req", 32'(mem_req), 32'h1);
        check("jmp_mem_addr", 32'(mem_addr), 32'h0010);
        mem_ready = 1'b1; mem_rdata = 16'h12FE;
        step();
        mem_ready = 1'b0;
        imm_sign_ext = 1'b1; #1;
        check("imm_sext_fe", 32'(immediate), 32'hFFFE);
        imm_sign_ext = 1'b0; #1;
        check("imm_zext_fe", 32'(immediate), 32'h00FE);

        // branch uses the sign-extended offset even with imm_sign_ext = 0
        pc_load = 1'b1; pc_src = 2'd1; fetch_en = 1'b1;
        step();
        pc_load = 1'b0; fetch_en = 1'b0;
        check("br_pc", 32'(pc), 32'h000E);
        check("br_mem_addr", 32'(mem_addr), 32'h000E);
        check("br_mem_req", 32'(mem_req), 32'h1);
        mem_ready = 1'b1; mem_rdata = 16'h457F;
        step();
        mem_ready = 1'b0;
        check("imm_zext_7f", 32'(immediate), 32'h007F);
        imm_sign_ext = 1'b1; #1;
        check("imm_sext_7f", 32'(immediate), 32'h007F);
        imm_sign_ext = 1'b0;

        // pc wrap-around from 0xFFFF
        pc_load = 1'b1; pc_src = 2'd2; jump_target = 16'hFFFF; fetch_en = 1'b1;
        step();
        pc_load = 1'b0; fetch_en = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h0000;
        step();
        mem_ready = 1'b0;
        check("wrap_pc_before", 32'(pc), 32'hFFFF);
        check("wrap_link_before", 32'(link_pc), 32'h0000);
        pc_load = 1'b1; pc_src = 2'd0;
        step();
        pc_load = 1'b0;
        check("wrap_pc_after", 32'(pc), 32'h0000);
        check("wrap_link_after", 32'(link_pc), 32'h0001);
        check("wrap_idle_req", 32'(mem_req), 32'h0);
        check("wrap_idle_valid", 32'(ins_valid), 32'h0);

        // pc_load outside VALID is ignored
        pc_load = 1'b1; pc_src = 2'd2; jump_target = 16'h1234; mem_ready = 1'b1;
        step();
        pc_load = 1'b0; mem_ready = 1'b0;
        check("idle_load_pc", 32'(pc), 32'h0000);
        check("idle_ready_req", 32'(mem_req), 32'h0);

        // timeout after 15 REQ cycles without mem_ready
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        repeat (14) step();
        check("to_pre_req", 32'(mem_req), 32'h1);
        check("to_pre_flag", 32'(fetch_timeout), 32'h0);
        step();
        check("to_flag", 32'(fetch_timeout), 32'h1);
        check("to_mem_req", 32'(mem_req), 32'h0);
        step();
        check("to_sticky", 32'(fetch_timeout), 32'h1);

        // retry at the same pc; ready on the last wait cycle wins
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        check("retry_flag", 32'(fetch_timeout), 32'h0);
        check("retry_req", 32'(mem_req), 32'h1);
        check("retry_addr", 32'(mem_addr), 32'h0000);
        repeat (14) step();
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ready = 1'b0;
        check("late_valid", 32'(ins_valid), 32'h1);
        check("late_flag", 32'(fetch_timeout), 32'h0);
        check("late_op_code", 32'(op_code), 32'hB);

        // jump with fetch_en: request next cycle at the jump target
        pc_load = 1'b1; pc_src = 2'd2; jump_target = 16'h0200; fetch_en = 1'b1;
        step();
        pc_load = 1'b0; fetch_en = 1'b0;
        check("jr_mem_req", 32'(mem_req), 32'h1);
        check("jr_mem_addr", 32'(mem_addr), 32'h0200);

        // asynchronous reset in REQ drops the request immediately
        reset = 1'b1;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'h0);
        check("arst_pc", 32'(pc), 32'h0000);
        check("arst_op_code", 32'(op_code), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_req", 32'(mem_req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
